// File: rtl/perf_pkg.sv
// Shared constants for the performance-counter bank: event channel numbering
// and the mapping from event channel to read index.
package perf_pkg;

  localparam int EVT_INST  = 0;
  localparam int EVT_IREQ  = 1;
  localparam int EVT_IHIT  = 2;
  localparam int EVT_DREQ  = 3;
  localparam int EVT_DHIT  = 4;
  localparam int EVT_STALL = 5;

  localparam int IDX_CYCLE = 0;

  // Read/counter index of event channel k; index 0 is the cycle counter.
  function automatic int evt_idx(input int k);
    return k + 1;
  endfunction

endpackage

// File: rtl/perf_ctr.sv
// Single performance counter with sticky overflow flag.
// Saturates or wraps on overflow, depending on SATURATE.
module perf_ctr #(
  parameter int CNT_W    = 32,
  parameter int SATURATE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] out,
  output logic             ovf
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (inc) begin
      if (&cnt_q) begin
        ovf_d = 1'b1;
        cnt_d = (SATURATE != 0) ? '1 : '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign out = cnt_q;
  assign ovf = ovf_q;

endmodule

// File: rtl/perf_counter_bank.sv
// Performance-monitor bank: cycle counter plus NUM_EVT event counters,
// halt/watchdog freeze, snapshot shadow bank and one-cycle read port.
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int          NUM_EVT     = 6,
  parameter int          CNT_W       = 32,
  parameter int          SATURATE    = 1,
  parameter int unsigned CYCLE_LIMIT = 100000,
  localparam int         IDX_W       = $clog2(NUM_EVT + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [NUM_EVT-1:0] evt,
  input  logic               halt,
  input  logic               clr,
  input  logic               snap,
  input  logic               rd_en,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic [CNT_W-1:0]   rd_data,
  output logic               rd_valid,
  output logic               halted,
  output logic               wdog,
  output logic [NUM_EVT:0]   ovf
);

  logic             halted_q, halted_d;
  logic             wdog_q, wdog_d;
  logic             rd_valid_q;
  logic [CNT_W-1:0] rd_data_q, rd_data_d;
  logic [CNT_W-1:0] shadow_q [NUM_EVT+1];
  logic [CNT_W-1:0] live     [NUM_EVT+1];
  logic [NUM_EVT:0] inc;
  logic [NUM_EVT:0] ovf_w;
  logic [CNT_W:0]   cyc_inc;
  logic             cnt_on;
  logic             wdog_hit;

  assign cnt_on = enable & ~halted_q & ~wdog_q;

  assign inc[IDX_CYCLE] = cnt_on;
  for (genvar k = 0; k < NUM_EVT; k++) begin : g_inc
    assign inc[evt_idx(k)] = cnt_on & evt[k];
  end

  for (genvar i = 0; i <= NUM_EVT; i++) begin : g_ctr
    perf_ctr #(
      .CNT_W   (CNT_W),
      .SATURATE(SATURATE)
    ) u_ctr (
      .clk  (clk),
      .rst_n(rst_n),
      .inc  (inc[i]),
      .clr  (clr),
      .out  (live[i]),
      .ovf  (ovf_w[i])
    );
  end

  // Extra bit so a limit above the counter range can never match.
  assign cyc_inc  = {1'b0, live[IDX_CYCLE]} + 1'b1;
  assign wdog_hit = (CYCLE_LIMIT != 0) && (65'(cyc_inc) == 65'(CYCLE_LIMIT));

  always_comb begin
    halted_d = halted_q;
    wdog_d   = wdog_q;
    if (clr) begin
      halted_d = 1'b0;
      wdog_d   = 1'b0;
    end else begin
      if (halt)              halted_d = 1'b1;
      if (cnt_on && wdog_hit) wdog_d  = 1'b1;
    end
  end

  always_comb begin
    rd_data_d = '0;
    for (int i = 0; i <= NUM_EVT; i++) begin
      if (rd_en && rd_idx == IDX_W'(i)) rd_data_d = shadow_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      halted_q   <= 1'b0;
      wdog_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      for (int i = 0; i <= NUM_EVT; i++) shadow_q[i] <= '0;
    end else begin
      halted_q   <= halted_d;
      wdog_q     <= wdog_d;
      rd_valid_q <= rd_en;
      rd_data_q  <= rd_data_d;
      // Shadow takes the pre-edge live values, so snap+clr keeps pre-clear counts.
      if (snap) begin
        for (int i = 0; i <= NUM_EVT; i++) shadow_q[i] <= live[i];
      end
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign halted   = halted_q;
  assign wdog     = wdog_q;
  assign ovf      = ovf_w;

endmodule
